// File: rtl/dither_pkg.sv
// Shared types and constants for the Floyd-Steinberg frame sequencer and its address generator.
package dither_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_QUANT = 3'd2,
      S_DIFF  = 3'd3,
      S_ADV   = 3'd4,
      S_DONE  = 3'd5
   } seq_state_t;

   typedef enum logic [1:0] {
      NB_R  = 2'd0,
      NB_DL = 2'd1,
      NB_D  = 2'd2,
      NB_DR = 2'd3
   } nb_sel_t;

   localparam int unsigned FS_W_R   = 7;
   localparam int unsigned FS_W_DL  = 3;
   localparam int unsigned FS_W_D   = 5;
   localparam int unsigned FS_W_DR  = 1;
   localparam int unsigned FS_SHIFT = 4;

   function automatic int unsigned fs_weight(input nb_sel_t sel);
      int unsigned w;
      w = FS_W_DR;
      case (sel)
         NB_R:    w = FS_W_R;
         NB_DL:   w = FS_W_DL;
         NB_D:    w = FS_W_D;
         default: w = FS_W_DR;
      endcase
      return w;
   endfunction

   // Lowest set bit of a non-empty legality mask, i.e. the next neighbour in visiting order.
   function automatic nb_sel_t lowest_set(input logic [3:0] mask);
      if (mask[0])      return NB_R;
      else if (mask[1]) return NB_DL;
      else if (mask[2]) return NB_D;
      else              return NB_DR;
   endfunction

   function automatic logic [3:0] remaining_after(input logic [3:0] mask, input nb_sel_t sel);
      return mask & ~((4'd2 << sel) - 4'd1);
   endfunction

endpackage

// File: rtl/dither_addr_gen.sv
// Raster x/y counters with an incrementally maintained pixel address, neighbour address
// and per-pixel neighbour legality mask.
module dither_addr_gen
   import dither_pkg::*;
#(
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int ADDR_W = 17,
   localparam int X_W   = $clog2(IMG_W),
   localparam int Y_W   = $clog2(IMG_H)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              adv,
   input  nb_sel_t           nb_sel,
   output logic [X_W-1:0]    cur_x,
   output logic [Y_W-1:0]    cur_y,
   output logic [ADDR_W-1:0] pix_addr,
   output logic [ADDR_W-1:0] nb_addr,
   output logic [3:0]        legal,
   output logic              last
);

   localparam logic [X_W-1:0] X_MAX = X_W'(IMG_W - 1);
   localparam logic [Y_W-1:0] Y_MAX = Y_W'(IMG_H - 1);

   logic [X_W-1:0]    x_q;
   logic [Y_W-1:0]    y_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] nb_off;
   logic              x_last;
   logic              y_last;

   assign x_last = (x_q == X_MAX);
   assign y_last = (y_q == Y_MAX);
   assign last   = x_last && y_last;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q    <= '0;
         y_q    <= '0;
         addr_q <= '0;
      end else if (clr) begin
         x_q    <= '0;
         y_q    <= '0;
         addr_q <= '0;
      end else if (adv) begin
         addr_q <= addr_q + ADDR_W'(1);
         if (x_last) begin
            x_q <= '0;
            y_q <= y_q + Y_W'(1);
         end else begin
            x_q <= x_q + X_W'(1);
         end
      end
   end

   // Raster order means every neighbour is a fixed forward offset from the current pixel.
   always_comb begin
      nb_off = ADDR_W'(1);
      case (nb_sel)
         NB_R:    nb_off = ADDR_W'(1);
         NB_DL:   nb_off = ADDR_W'(IMG_W - 1);
         NB_D:    nb_off = ADDR_W'(IMG_W);
         default: nb_off = ADDR_W'(IMG_W + 1);
      endcase
   end

   assign nb_addr = addr_q + nb_off;

   assign legal[NB_R]  = !x_last;
   assign legal[NB_DL] = (x_q != '0) && !y_last;
   assign legal[NB_D]  = !y_last;
   assign legal[NB_DR] = !x_last && !y_last;

   assign cur_x    = x_q;
   assign cur_y    = y_q;
   assign pix_addr = addr_q;

endmodule

// File: rtl/dither_frame_sequencer.sv
// Frame-level scheduler: walks the image in raster order, sequencing load, quantise and
// error diffusion to each legal neighbour, with every memory access stallable by its ack.
module dither_frame_sequencer
   import dither_pkg::*;
#(
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int ADDR_W = 17,
   localparam int X_W   = $clog2(IMG_W),
   localparam int Y_W   = $clog2(IMG_H)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [X_W-1:0]    cur_x,
   output logic [Y_W-1:0]    cur_y,
   output logic [ADDR_W-1:0] pix_addr,
   output logic              rd_req,
   input  logic              rd_ack,
   output logic              quant_en,
   output logic              nb_req,
   output logic [1:0]        nb_sel,
   output logic [ADDR_W-1:0] nb_addr,
   input  logic              nb_ack
);

   localparam logic [2:0] ST_IDLE  = 3'(S_IDLE);
   localparam logic [2:0] ST_LOAD  = 3'(S_LOAD);
   localparam logic [2:0] ST_QUANT = 3'(S_QUANT);
   localparam logic [2:0] ST_DIFF  = 3'(S_DIFF);
   localparam logic [2:0] ST_ADV   = 3'(S_ADV);
   localparam logic [2:0] ST_DONE  = 3'(S_DONE);

   logic [2:0]        state_q, state_d;
   nb_sel_t           nb_sel_q, nb_sel_d;
   logic              clr, adv, last;
   logic [3:0]        legal, rest;
   logic [ADDR_W-1:0] nb_addr_raw;

   dither_addr_gen #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .adv      (adv),
      .nb_sel   (nb_sel_q),
      .cur_x    (cur_x),
      .cur_y    (cur_y),
      .pix_addr (pix_addr),
      .nb_addr  (nb_addr_raw),
      .legal    (legal),
      .last     (last)
   );

   assign rest = remaining_after(legal, nb_sel_q);

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      nb_sel_d = nb_sel_q;
      clr      = 1'b0;
      adv      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               clr     = 1'b1;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (rd_ack) state_d = ST_QUANT;
         end
         ST_QUANT: begin
            if (|legal) begin
               state_d  = ST_DIFF;
               nb_sel_d = lowest_set(legal);
            end else begin
               state_d  = ST_ADV;
            end
         end
         ST_DIFF: begin
            if (nb_ack) begin
               if (|rest) begin
                  nb_sel_d = lowest_set(rest);
               end else begin
                  state_d  = ST_ADV;
               end
            end
         end
         ST_ADV: begin
            if (last) begin
               state_d = ST_DONE;
            end else begin
               adv     = 1'b1;
               state_d = ST_LOAD;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Abort freezes the position: the pending advance is dropped along with the frame.
      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         adv     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         nb_sel_q <= NB_R;
      end else begin
         state_q  <= state_d;
         nb_sel_q <= nb_sel_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign rd_req   = (state_q == ST_LOAD);
   assign quant_en = (state_q == ST_QUANT);
   assign nb_req   = (state_q == ST_DIFF);
   assign nb_sel   = nb_req ? nb_sel_q : NB_R;
   assign nb_addr  = nb_req ? nb_addr_raw : '0;

endmodule

// File: tb/tb_dither_frame_sequencer.sv
// Self-checking bench: a 4x3 instance walked cycle by cycle against a raster/legality model,
// plus a 2x2 instance driven with random ack delays.
module tb_dither_frame_sequencer;

   localparam int AW  = 4;
   localparam int AH  = 3;
   localparam int AAW = 17;
   localparam int AXW = 2;
   localparam int AYW = 2;
   localparam int AN  = AW * AH;
   localparam int VW  = 5 + 2 + AAW + AAW + AXW + AYW;
   localparam int BW  = 2;
   localparam int BH  = 2;
   localparam int BAW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic start_a, abort_a, rd_ack_a, nb_ack_a;
   logic busy_a, done_a, rd_req_a, quant_en_a, nb_req_a;
   logic [AXW-1:0] cur_x_a;
   logic [AYW-1:0] cur_y_a;
   logic [AAW-1:0] pix_addr_a, nb_addr_a;
   logic [1:0]     nb_sel_a;

   logic start_b, abort_b, rd_ack_b, nb_ack_b;
   logic busy_b, done_b, rd_req_b, quant_en_b, nb_req_b;
   logic [0:0]     cur_x_b, cur_y_b;
   logic [BAW-1:0] pix_addr_b, nb_addr_b;
   logic [1:0]     nb_sel_b;

   int checks = 0;
   int failures = 0;
   int cyc_a, tally_busy, tally_q, tally_nb, tally_done_cyc;
   bit noisy_a;
   logic [VW-1:0] care_all, care_no_nb, care_flags;
   logic [1:0]     obs_sel  [AN][4];
   logic [AAW-1:0] obs_addr [AN][4];
   int             obs_n    [AN];

   dither_frame_sequencer #(.IMG_W(AW), .IMG_H(AH), .ADDR_W(AAW)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .busy(busy_a), .done(done_a),
      .cur_x(cur_x_a), .cur_y(cur_y_a), .pix_addr(pix_addr_a), .rd_req(rd_req_a), .rd_ack(rd_ack_a),
      .quant_en(quant_en_a), .nb_req(nb_req_a), .nb_sel(nb_sel_a), .nb_addr(nb_addr_a), .nb_ack(nb_ack_a)
   );

   dither_frame_sequencer #(.IMG_W(BW), .IMG_H(BH), .ADDR_W(BAW)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b),
      .cur_x(cur_x_b), .cur_y(cur_y_b), .pix_addr(pix_addr_b), .rd_req(rd_req_b), .rd_ack(rd_ack_b),
      .quant_en(quant_en_b), .nb_req(nb_req_b), .nb_sel(nb_sel_b), .nb_addr(nb_addr_b), .nb_ack(nb_ack_b)
   );

   function automatic logic [VW-1:0] obs_a();
      return {busy_a, done_a, rd_req_a, quant_en_a, nb_req_a, nb_sel_a, nb_addr_a, pix_addr_a, cur_x_a, cur_y_a};
   endfunction

   function automatic logic [VW-1:0] mk(input bit b, dn, r, q, n, input int sel, na, pa, x, y);
      return {b, dn, r, q, n, 2'(sel), AAW'(na), AAW'(pa), AXW'(x), AYW'(y)};
   endfunction

   function automatic bit nb_legal(input int x, y, n, w, h);
      case (n)
         0:       return x < w - 1;
         1:       return x > 0 && y < h - 1;
         2:       return y < h - 1;
         default: return x < w - 1 && y < h - 1;
      endcase
   endfunction

   function automatic int nb_offset(input int n, w);
      case (n)
         0:       return 1;
         1:       return w - 1;
         2:       return w;
         default: return w + 1;
      endcase
   endfunction

   function automatic int count_legal(input int w, h);
      int total = 0;
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++)
            for (int n = 0; n < 4; n++)
               total += int'(nb_legal(x, y, n, w, h));
      return total;
   endfunction

   task automatic tick_a(input bit last);
      tally_busy += int'(busy_a);
      tally_q    += int'(quant_en_a);
      tally_nb   += int'(nb_req_a);
      if (done_a) tally_done_cyc = cyc_a;
      start_a = (noisy_a && !last) ? 1'($urandom_range(1, 0)) : 1'b0;
      @(negedge clk);
      cyc_a++;
   endtask

   // Starts a frame on dut_a and checks every cycle against the raster walk; the cycle of
   // the DONE pulse is counted with the start edge as cycle 0.
   task automatic walk_frame(input int max_dly, input bit tie, input bit noisy,
                             input int stall_pix, input int stall_len,
                             input int abort_pix, input int abort_ord,
                             output int exp_done, output bit aborted);
      int px, py, d, ord;
      logic [VW-1:0] ov, ev;
      exp_done = 0; aborted = 1'b0;
      tally_busy = 0; tally_q = 0; tally_nb = 0; tally_done_cyc = -1;
      noisy_a = noisy;
      @(negedge clk);
      start_a = 1'b1; rd_ack_a = tie; nb_ack_a = tie;
      @(negedge clk);
      start_a = 1'b0; cyc_a = 1;
      for (int p = 0; p < AN; p++) begin
         px = p % AW; py = p / AW; obs_n[p] = 0;
         d = (p == stall_pix) ? stall_len : (tie ? 0 : int'($urandom_range(max_dly, 0)));
         exp_done += d + 3;
         for (int k = 0; k <= d; k++) begin
            ov = obs_a(); ev = mk(1, 0, 1, 0, 0, 0, 0, p, px, py);
            checks++;
            if (((ov ^ ev) & care_no_nb) != '0) begin
               failures++;
               $display("FAIL load p=%0d cyc=%0d got=%h exp=%h", p, cyc_a, ov & care_no_nb, ev);
            end
            rd_ack_a = tie || (k == d);
            tick_a(1'b0);
         end
         rd_ack_a = tie;
         ov = obs_a(); ev = mk(1, 0, 0, 1, 0, 0, 0, p, px, py);
         checks++;
         if (((ov ^ ev) & care_no_nb) != '0) begin
            failures++;
            $display("FAIL quant p=%0d cyc=%0d got=%h exp=%h", p, cyc_a, ov & care_no_nb, ev);
         end
         tick_a(1'b0);
         ord = 0;
         for (int n = 0; n < 4; n++) begin
            if (!nb_legal(px, py, n, AW, AH)) continue;
            d = tie ? 0 : int'($urandom_range(max_dly, 0));
            exp_done += d + 1;
            for (int k = 0; k <= d; k++) begin
               ov = obs_a(); ev = mk(1, 0, 0, 0, 1, n, p + nb_offset(n, AW), p, px, py);
               checks++;
               if (((ov ^ ev) & care_all) != '0) begin
                  failures++;
                  $display("FAIL diff p=%0d n=%0d cyc=%0d got=%h exp=%h", p, n, cyc_a, ov, ev);
               end
               if (k == 0) begin
                  obs_sel[p][obs_n[p]]  = nb_sel_a;
                  obs_addr[p][obs_n[p]] = nb_addr_a;
                  obs_n[p]++;
               end
               if (p == abort_pix && ord == abort_ord) begin
                  abort_a = 1'b1; nb_ack_a = 1'b0;
                  tick_a(1'b0);
                  abort_a = 1'b0; rd_ack_a = 1'b0;
                  ov = obs_a(); ev = mk(0, 0, 0, 0, 0, 0, 0, p, px, py);
                  checks++;
                  if (((ov ^ ev) & care_no_nb) != '0) begin
                     failures++;
                     $display("FAIL abort_state got=%h exp=%h", ov & care_no_nb, ev);
                  end
                  aborted = 1'b1;
                  return;
               end
               nb_ack_a = tie || (k == d);
               tick_a(1'b0);
            end
            nb_ack_a = tie;
            ord++;
         end
         ov = obs_a(); ev = mk(1, 0, 0, 0, 0, 0, 0, p, px, py);
         checks++;
         if (((ov ^ ev) & care_no_nb) != '0) begin
            failures++;
            $display("FAIL adv p=%0d cyc=%0d got=%h exp=%h", p, cyc_a, ov & care_no_nb, ev);
         end
         tick_a(1'b0);
      end
      exp_done += 1;
      ov = obs_a(); ev = mk(1, 1, 0, 0, 0, 0, 0, AN - 1, AW - 1, AH - 1);
      checks++;
      if (((ov ^ ev) & care_no_nb) != '0) begin
         failures++;
         $display("FAIL done_cycle cyc=%0d got=%h exp=%h", cyc_a, ov & care_no_nb, ev);
      end
      tick_a(1'b1);
      rd_ack_a = 1'b0; nb_ack_a = 1'b0; noisy_a = 1'b0;
      ov = obs_a();
      checks++;
      if ((ov & care_flags) != '0) begin
         failures++;
         $display("FAIL back_to_idle got=%h exp=0", ov & care_flags);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ((obs_a() & care_all) != '0) begin
         failures++;
         $display("FAIL reset_a got=%h exp=0", obs_a());
      end
      checks++;
      if ({busy_b, done_b, rd_req_b, quant_en_b, nb_req_b, nb_sel_b, nb_addr_b, pix_addr_b} !== '0) begin
         failures++;
         $display("FAIL reset_b busy=%b addr=%h", busy_b, pix_addr_b);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_idle_controls();
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      checks++;
      if (busy_a !== 1'b0) begin
         failures++;
         $display("FAIL idle_abort busy got=%b exp=0", busy_a);
      end
      start_a = 1'b1; abort_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0; abort_a = 1'b0;
      checks++;
      if ({busy_a, rd_req_a, pix_addr_a} !== {1'b1, 1'b1, AAW'(0)}) begin
         failures++;
         $display("FAIL start_beats_abort busy=%b rd_req=%b addr=%0d exp 1 1 0", busy_a, rd_req_a, pix_addr_a);
      end
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      checks++;
      if ({busy_a, rd_req_a} !== 2'b00) begin
         failures++;
         $display("FAIL abort_in_load busy=%b rd_req=%b exp 0 0", busy_a, rd_req_a);
      end
   endtask

   task automatic test_full_frame();
      int exp_done; bit ab;
      checks++;
      if (busy_a !== 1'b0) begin
         failures++;
         $display("FAIL busy_before_start got=%b exp=0", busy_a);
      end
      walk_frame(0, 1'b1, 1'b0, -1, 0, -1, -1, exp_done, ab);
      checks++;
      if (tally_done_cyc != 66) begin
         failures++;
         $display("FAIL full_done_cycle got=%0d exp=66", tally_done_cyc);
      end
      checks++;
      if (tally_busy != 66) begin
         failures++;
         $display("FAIL full_busy_cycles got=%0d exp=66", tally_busy);
      end
      checks++;
      if (tally_q != AN) begin
         failures++;
         $display("FAIL full_quant_pulses got=%0d exp=%0d", tally_q, AN);
      end
      checks++;
      if (tally_nb != count_legal(AW, AH)) begin
         failures++;
         $display("FAIL full_nb_cycles got=%0d exp=%0d", tally_nb, count_legal(AW, AH));
      end
   endtask

   task automatic test_neighbour_order();
      int exp5 [4] = '{6, 8, 9, 10};
      checks++;
      if (obs_n[0] != 3 || {obs_sel[0][0], obs_sel[0][1], obs_sel[0][2]} !== 6'b00_10_11) begin
         failures++;
         $display("FAIL order_p00 n=%0d sel=%0d,%0d,%0d exp 3: 0,2,3", obs_n[0], obs_sel[0][0], obs_sel[0][1], obs_sel[0][2]);
      end
      checks++;
      if (obs_n[3] != 2 || {obs_sel[3][0], obs_sel[3][1]} !== 4'b01_10) begin
         failures++;
         $display("FAIL order_p30 n=%0d sel=%0d,%0d exp 2: 1,2", obs_n[3], obs_sel[3][0], obs_sel[3][1]);
      end
      checks++;
      if (obs_n[11] != 0) begin
         failures++;
         $display("FAIL order_p32 n=%0d exp=0", obs_n[11]);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (obs_n[5] != 4 || obs_addr[5][i] != AAW'(exp5[i])) begin
            failures++;
            $display("FAIL addr_p11 idx=%0d n=%0d got=%0d exp=%0d", i, obs_n[5], obs_addr[5][i], exp5[i]);
         end
      end
   endtask

   task automatic test_rd_stall();
      int exp_done; bit ab;
      walk_frame(0, 1'b0, 1'b0, 6, 5, -1, -1, exp_done, ab);
      checks++;
      if (tally_done_cyc != 71 || exp_done != 71) begin
         failures++;
         $display("FAIL stall_done_cycle got=%0d exp=71", tally_done_cyc);
      end
   endtask

   task automatic test_abort();
      int exp_done, dones; bit ab;
      walk_frame(0, 1'b0, 1'b0, -1, 0, 5, 2, exp_done, ab);
      checks++;
      if (ab !== 1'b1) begin
         failures++;
         $display("FAIL abort_reached got=%b exp=1", ab);
      end
      dones = 0;
      repeat (6) begin
         dones += int'(done_a) + int'(busy_a);
         @(negedge clk);
      end
      checks++;
      if (dones != 0) begin
         failures++;
         $display("FAIL abort_quiet done_or_busy_cycles got=%0d exp=0", dones);
      end
      walk_frame(0, 1'b1, 1'b0, -1, 0, -1, -1, exp_done, ab);
      checks++;
      if (tally_done_cyc != 66) begin
         failures++;
         $display("FAIL restart_done_cycle got=%0d exp=66", tally_done_cyc);
      end
   endtask

   task automatic test_random_acks();
      int exp_done; bit ab;
      for (int f = 0; f < 3; f++) begin
         walk_frame(3, 1'b0, 1'b1, -1, 0, -1, -1, exp_done, ab);
         checks++;
         if (tally_done_cyc != exp_done) begin
            failures++;
            $display("FAIL random_done_cycle frame=%0d got=%0d exp=%0d", f, tally_done_cyc, exp_done);
         end
      end
   endtask

   task automatic test_reset_midframe();
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0; rd_ack_a = 1'b1; nb_ack_a = 1'b1;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; rd_ack_a = 1'b0; nb_ack_a = 1'b0;
      checks++;
      if ((obs_a() & care_all) != '0) begin
         failures++;
         $display("FAIL reset_midframe got=%h exp=0", obs_a());
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy_a !== 1'b0) begin
         failures++;
         $display("FAIL reset_stays_idle busy got=%b exp=0", busy_a);
      end
   endtask

   task automatic test_small_frame();
      int rd_cnt, rd_d, nb_cnt, nb_d, writes, dones, viol, cyc;
      bit seen_done;
      rd_cnt = 0; nb_cnt = 0; writes = 0; dones = 0; viol = 0; seen_done = 1'b0;
      rd_d = int'($urandom_range(3, 0)); nb_d = int'($urandom_range(3, 0));
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (cyc = 0; cyc < 400 && !(seen_done && !busy_b); cyc++) begin
         if (done_b) begin dones++; seen_done = 1'b1; end
         if (nb_req_b && nb_addr_b >= BAW'(BW * BH)) viol++;
         rd_ack_b = 1'b0;
         if (rd_req_b) begin
            if (rd_cnt == rd_d) begin
               rd_ack_b = 1'b1; rd_cnt = 0; rd_d = int'($urandom_range(3, 0));
            end else rd_cnt++;
         end
         nb_ack_b = 1'b0;
         if (nb_req_b) begin
            if (nb_cnt == nb_d) begin
               nb_ack_b = 1'b1; nb_cnt = 0; nb_d = int'($urandom_range(3, 0)); writes++;
            end else nb_cnt++;
         end
         @(negedge clk);
      end
      rd_ack_b = 1'b0; nb_ack_b = 1'b0;
      repeat (5) begin
         dones += int'(done_b);
         @(negedge clk);
      end
      checks++;
      if (dones != 1) begin
         failures++;
         $display("FAIL small_done_count got=%0d exp=1 (cycles=%0d)", dones, cyc);
      end
      checks++;
      if (writes != count_legal(BW, BH)) begin
         failures++;
         $display("FAIL small_nb_writes got=%0d exp=%0d", writes, count_legal(BW, BH));
      end
      checks++;
      if (viol != 0) begin
         failures++;
         $display("FAIL small_nb_addr_range out_of_range_cycles=%0d exp=0", viol);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start_a = 1'b0; abort_a = 1'b0; rd_ack_a = 1'b0; nb_ack_a = 1'b0;
      start_b = 1'b0; abort_b = 1'b0; rd_ack_b = 1'b0; nb_ack_b = 1'b0;
      noisy_a = 1'b0;
      care_all   = mk(1, 1, 1, 1, 1, -1, -1, -1, -1, -1);
      care_no_nb = mk(1, 1, 1, 1, 1, 0, 0, -1, -1, -1);
      care_flags = mk(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
      test_reset();
      test_idle_controls();
      test_full_frame();
      test_neighbour_order();
      test_rd_stall();
      test_abort();
      test_random_acks();
      test_reset_midframe();
      test_small_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
